// File: rtl/mem_data_loader.sv
// mem_data_loader: assembles a low-byte-first serial stream into 16-bit words
// and writes them to consecutive data-memory addresses, stalling the CPU while
// a load runs. When idle, the CPU owns the memory port combinationally.
module mem_data_loader #(
    parameter int unsigned p_DATA_MEM_SIZE = 1024,
    parameter int unsigned p_WORD_LEN      = 16,
    parameter int unsigned p_ADDR_LEN      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [p_ADDR_LEN-1:0] baseAddr,
    input  logic [p_ADDR_LEN-1:0] wordCount,
    input  logic [7:0]            byteIn,
    input  logic                  byteValid,
    output logic                  byteReady,
    input  logic [p_ADDR_LEN-1:0] cpuAddress,
    input  logic [p_WORD_LEN-1:0] cpuDataIn,
    input  logic                  cpuWriteEn,
    output logic [p_ADDR_LEN-1:0] memAddress,
    output logic [p_WORD_LEN-1:0] memDataIn,
    output logic                  memWriteEn,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LO    = 3'd1,
        HI    = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t                state;
    logic [p_ADDR_LEN-1:0] addr_reg;
    logic [p_ADDR_LEN-1:0] cnt_reg;
    logic [7:0]            lo_reg;
    logic [7:0]            hi_reg;
    logic                  we_reg;
    logic                  busy_reg;
    logic                  ready_reg;
    logic                  done_reg;
    logic                  error_reg;
    logic                  addr_in_range;
    logic                  idle;

    // Out-of-range words are counted but never reach memory.
    assign addr_in_range = (64'(addr_reg) < 64'(p_DATA_MEM_SIZE));
    assign idle          = (state == IDLE);

    // Loader FSM; all status outputs are registered alongside the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            addr_reg  <= '0;
            cnt_reg   <= '0;
            lo_reg    <= '0;
            hi_reg    <= '0;
            we_reg    <= 1'b0;
            busy_reg  <= 1'b0;
            ready_reg <= 1'b0;
            done_reg  <= 1'b0;
            error_reg <= 1'b0;
        end else begin
            we_reg   <= 1'b0;
            done_reg <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        busy_reg <= 1'b1;
                        if (wordCount == '0) begin
                            state    <= DONE;
                            done_reg <= 1'b1;
                        end else begin
                            addr_reg  <= baseAddr;
                            cnt_reg   <= wordCount;
                            error_reg <= 1'b0;
                            ready_reg <= 1'b1;
                            state     <= LO;
                        end
                    end
                end
                LO: begin
                    if (byteValid) begin
                        lo_reg <= byteIn;
                        state  <= HI;
                    end
                end
                HI: begin
                    if (byteValid) begin
                        hi_reg    <= byteIn;
                        ready_reg <= 1'b0;
                        we_reg    <= addr_in_range;
                        if (!addr_in_range) begin
                            error_reg <= 1'b1;
                        end
                        state     <= WRITE;
                    end
                end
                WRITE: begin
                    addr_reg <= addr_reg + p_ADDR_LEN'(1);
                    cnt_reg  <= cnt_reg - p_ADDR_LEN'(1);
                    if (cnt_reg == p_ADDR_LEN'(1)) begin
                        done_reg <= 1'b1;
                        state    <= DONE;
                    end else begin
                        ready_reg <= 1'b1;
                        state     <= LO;
                    end
                end
                DONE: begin
                    busy_reg <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    busy_reg  <= 1'b0;
                    ready_reg <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

    // Memory port: CPU passthrough when idle (gated by reset), loader registers otherwise.
    assign memAddress = idle ? cpuAddress : addr_reg;
    assign memDataIn  = idle ? cpuDataIn  : p_WORD_LEN'({hi_reg, lo_reg});
    assign memWriteEn = idle ? (cpuWriteEn & ~rst) : we_reg;

    assign byteReady = ready_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;
    assign error     = error_reg;

endmodule

// File: tb/tb_mem_data_loader.sv
// tb_mem_data_loader: directed and randomized loads checked against a
// word-level model of the load (address sequence, data, error, timing).
module tb_mem_data_loader;

    localparam int unsigned AW       = 16;
    localparam int unsigned WW       = 16;
    localparam int unsigned MEM_SIZE = 1024;

    logic          clk;
    logic          rst;
    logic          start;
    logic [AW-1:0] baseAddr;
    logic [AW-1:0] wordCount;
    logic [7:0]    byteIn;
    logic          byteValid;
    logic          byteReady;
    logic [AW-1:0] cpuAddress;
    logic [WW-1:0] cpuDataIn;
    logic          cpuWriteEn;
    logic [AW-1:0] memAddress;
    logic [WW-1:0] memDataIn;
    logic          memWriteEn;
    logic          busy;
    logic          done;
    logic          error;

    int            n_cmp;
    int            n_fail;
    logic [7:0]    bytes_q[$];
    logic [WW-1:0] mem[int];
    logic [WW-1:0] ref_mem[int];
    logic          model_err;
    int            g_first_wr;

    mem_data_loader #(
        .p_DATA_MEM_SIZE(MEM_SIZE),
        .p_WORD_LEN     (WW),
        .p_ADDR_LEN     (AW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .baseAddr  (baseAddr),
        .wordCount (wordCount),
        .byteIn    (byteIn),
        .byteValid (byteValid),
        .byteReady (byteReady),
        .cpuAddress(cpuAddress),
        .cpuDataIn (cpuDataIn),
        .cpuWriteEn(cpuWriteEn),
        .memAddress(memAddress),
        .memDataIn (memDataIn),
        .memWriteEn(memWriteEn),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One load: model computes expected writes/error/done cycle, then the
    // stream is driven with an optional stall, restart pulse or reset abort.
    task automatic run_load(input logic [AW-1:0] base, input logic [AW-1:0] cnt,
                            input int gap_at, input int gap_len,
                            input int restart_t, input int abort_t);
        logic [AW-1:0] exp_a[$];
        logic [WW-1:0] exp_d[$];
        logic [AW-1:0] got_a[$];
        logic [WW-1:0] got_d[$];
        logic [AW-1:0] a;
        logic [WW-1:0] d;
        int            n_words, exp_done, t, done_t, done_cnt, idx, gap_left;
        logic          exp_err, cons, err_after, busy_after, aborted;

        while (bytes_q.size() < 2 * int'(cnt)) bytes_q.push_back(8'($urandom));

        n_words = (abort_t > 0) ? (abort_t - 1) / 3 : int'(cnt);
        exp_err = 1'b0;
        for (int i = 0; i < n_words; i++) begin
            a = AW'(32'(base) + 32'(i));
            d = {bytes_q[2*i+1], bytes_q[2*i]};
            if (32'(a) < MEM_SIZE) begin
                exp_a.push_back(a);
                exp_d.push_back(d);
                ref_mem[int'(a)] = d;
            end else begin
                exp_err = 1'b1;
            end
        end
        exp_done = (cnt == '0) ? 1 : 3 * int'(cnt) + 1 + gap_len;
        if (abort_t == 0 && cnt != '0) model_err = exp_err;

        @(posedge clk); #1;
        baseAddr   = base;
        wordCount  = cnt;
        start      = 1'b1;
        cpuWriteEn = 1'b0;
        cpuAddress = '0;
        cpuDataIn  = '0;
        idx        = 0;
        gap_left   = 0;
        byteValid  = (cnt != '0);
        byteIn     = (bytes_q.size() > 0) ? bytes_q[0] : 8'h00;
        t          = 0;
        done_t     = -1;
        done_cnt   = 0;
        aborted    = 1'b0;
        err_after  = 1'bx;
        busy_after = 1'bx;
        g_first_wr = -1;

        while (t < 400) begin
            @(negedge clk);
            if (t == 0) check("busy_at_start", 32'(busy), 32'd0);
            if (gap_left > 0) begin
                check("stall_ready", 32'(byteReady), 32'd1);
                check("stall_no_write", 32'(memWriteEn), 32'd0);
            end
            if (memWriteEn) begin
                mem[int'(memAddress)] = memDataIn;
                got_a.push_back(memAddress);
                got_d.push_back(memDataIn);
                if (g_first_wr < 0) g_first_wr = t;
            end
            if (done) begin
                done_cnt++;
                if (done_t < 0) begin
                    done_t = t;
                    check("busy_in_done", 32'(busy), 32'd1);
                end
            end
            if (done_t >= 0 && t == done_t + 1) begin
                err_after  = error;
                busy_after = busy;
            end
            cons = byteReady && byteValid;
            if (done_t >= 0 && t >= done_t + 1) break;

            @(posedge clk); #1;
            t++;
            start = (t == restart_t);
            if (start) begin
                baseAddr  = AW'($urandom);
                wordCount = cnt + 16'd3;
            end
            if (t == abort_t) begin
                start = 1'b0;
                #2;
                rst        = 1'b1;
                cpuWriteEn = 1'b1;
                cpuAddress = AW'($urandom_range(0, MEM_SIZE - 1));
                cpuDataIn  = WW'($urandom);
                #1;
                check("rst_busy", 32'(busy), 32'd0);
                check("rst_ready", 32'(byteReady), 32'd0);
                check("rst_done", 32'(done), 32'd0);
                check("rst_error", 32'(error), 32'd0);
                check("rst_we_gated", 32'(memWriteEn), 32'd0);
                model_err = 1'b0;
                #3;
                rst       = 1'b0;
                byteValid = 1'b0;
                #1;
                check("cpu_we", 32'(memWriteEn), 32'd1);
                check("cpu_addr", 32'(memAddress), 32'(cpuAddress));
                check("cpu_data", 32'(memDataIn), 32'(cpuDataIn));
                ref_mem[int'(cpuAddress)] = cpuDataIn;
                @(negedge clk);
                if (memWriteEn) mem[int'(memAddress)] = memDataIn;
                @(posedge clk); #1;
                cpuWriteEn = 1'b0;
                aborted    = 1'b1;
                break;
            end
            if (t <= exp_done) begin
                cpuWriteEn = 1'($urandom);
                cpuAddress = AW'($urandom);
                cpuDataIn  = WW'($urandom);
            end else begin
                cpuWriteEn = 1'b0;
            end
            if (cons) begin
                idx++;
                if (idx == gap_at) gap_left = gap_len;
            end else if (gap_left > 0) begin
                gap_left--;
            end
            byteValid = (idx < 2 * int'(cnt)) && (gap_left == 0);
            byteIn    = byteValid ? bytes_q[idx] : 8'($urandom);
        end

        check("num_writes", 32'(got_a.size()), 32'(exp_a.size()));
        for (int i = 0; i < got_a.size() && i < exp_a.size(); i++) begin
            check("write_addr", 32'(got_a[i]), 32'(exp_a[i]));
            check("write_data", 32'(got_d[i]), 32'(exp_d[i]));
        end
        if (!aborted) begin
            check("done_pulses", 32'(done_cnt), 32'd1);
            check("done_cycle", 32'(done_t), 32'(exp_done));
            check("error_after", 32'(err_after), 32'(model_err));
            check("busy_after", 32'(busy_after), 32'd0);
        end
        start     = 1'b0;
        byteValid = 1'b0;
        bytes_q.delete();
    endtask

    // Directed scenarios followed by randomized loads and a final memory audit.
    initial begin
        int c;
        int diffs;
        n_cmp      = 0;
        n_fail     = 0;
        model_err  = 1'b0;
        g_first_wr = -1;
        rst        = 1'b1;
        start      = 1'b0;
        baseAddr   = '0;
        wordCount  = '0;
        byteIn     = '0;
        byteValid  = 1'b0;
        cpuAddress = 16'h0123;
        cpuDataIn  = 16'hBEEF;
        cpuWriteEn = 1'b1;

        #3;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_ready", 32'(byteReady), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_error", 32'(error), 32'd0);
        check("reset_we", 32'(memWriteEn), 32'd0);
        check("reset_addr_pass", 32'(memAddress), 32'h0123);
        repeat (2) @(posedge clk);
        #2;
        rst        = 1'b0;
        cpuWriteEn = 1'b0;

        bytes_q = {8'h34, 8'h12, 8'h78, 8'h56};
        run_load(16'h0010, 16'd2, 0, 0, 0, 0);
        check("first_write_cycle", 32'(g_first_wr), 32'd3);

        run_load(16'h0200, 16'd0, 0, 0, 0, 0);

        run_load(16'h03FF, 16'd2, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        check("error_sticky", 32'(error), 32'd1);

        run_load(16'h0100, 16'd2, 1, 5, 0, 0);

        run_load(16'h0040, 16'd3, 0, 0, 4, 0);

        run_load(16'hFFFF, 16'd2, 0, 0, 0, 0);

        for (int k = 0; k < 6; k++) begin
            c = int'($urandom_range(1, 4));
            run_load(AW'($urandom_range(0, 1100)), AW'(c),
                     2 * int'($urandom_range(0, c - 1)) + 1,
                     int'($urandom_range(0, 4)), 0, 0);
        end

        run_load(16'h0080, 16'd3, 0, 0, 0, 5);
        run_load(16'h0300, 16'd1, 0, 0, 0, 0);

        diffs = 0;
        foreach (ref_mem[a]) begin
            if (!mem.exists(a)) diffs++;
            else if (mem[a] !== ref_mem[a]) diffs++;
        end
        check("mem_contents", 32'(diffs), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
